// File: rtl/buffer_pkg.sv
// Shared width helpers and read-side FSM encoding for the circular-buffer reader.
package buffer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } rd_state_t;

  localparam int DROP_CNT_W = 8;

  // Buffer read address width; a one-word buffer still gets a 1-bit address.
  function automatic int addr_w(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  // Occupancy must represent 0..size inclusive.
  function automatic int cnt_w(input int size);
    return $clog2(size) + 1;
  endfunction

endpackage

// File: rtl/buf_occ_counter.sv
// Occupancy tracker: word count, write-space flag and sticky overflow.
// Optional saturating drop counter when BUFFER_READER_DROP_CNT_EN is defined.
module buf_occ_counter
  import buffer_pkg::*;
#(
  parameter int SIZE = 16,
  parameter int K    = 4,
  parameter int J    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ld_i,
  input  logic                   fire_i,
  output logic [cnt_w(SIZE)-1:0] count_o,
  output logic                   wr_ok_o,
  output logic                   overflow_o
`ifdef BUFFER_READER_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]  drop_cnt_o
`endif
);

  localparam int CW = cnt_w(SIZE);
  localparam logic [CW-1:0] K_C   = CW'(K);
  localparam logic [CW-1:0] J_C   = CW'(J);
  localparam logic [CW-1:0] LIMIT = CW'(SIZE - K);

  logic [CW-1:0] count_q, count_d;
  logic          overflow_q;
  logic          wr_ok;
  logic          accept;

  assign wr_ok  = (count_q <= LIMIT);
  assign accept = ld_i && wr_ok;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (accept) count_d = count_d + K_C;
    if (fire_i) count_d = count_d - J_C;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (ld_i && !wr_ok) overflow_q <= 1'b1;
    end
  end

`ifdef BUFFER_READER_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q <= '0;
    end else if (ld_i && !wr_ok && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
      drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

  assign count_o    = count_q;
  assign wr_ok_o    = wr_ok;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/buffer_reader.sv
// Circular-buffer reader: pulls J-word bursts once enough words are committed
// and hands them to a ready/valid consumer. BUFFER_READER_DROP_CNT_EN adds drop_cnt.
module buffer_reader
  import buffer_pkg::*;
#(
  parameter int SIZE  = 16,
  parameter int WIDTH = 8,
  parameter int K     = 4,
  parameter int J     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld,
  output logic                    wr_ok,
  output logic [addr_w(SIZE)-1:0] read_add,
  input  logic [WIDTH*J-1:0]      par_in,
  output logic [WIDTH*J-1:0]      par_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow
`ifdef BUFFER_READER_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]   drop_cnt
`endif
);

  localparam int AW = addr_w(SIZE);
  localparam int CW = cnt_w(SIZE);

  rd_state_t          state_q;
  logic               out_valid_q;
  logic [WIDTH*J-1:0] par_out_q;
  logic [AW-1:0]      read_add_q, read_add_d;
  logic [AW:0]        ra_sum;
  logic [CW-1:0]      count;
  logic               fire;

  // A held burst can be replaced on the same edge the consumer takes it.
  assign fire = (count >= CW'(J)) && ((state_q == IDLE) || out_ready);

  // One extra bit covers read_add + J < 2*SIZE, so a single subtract wraps it.
  always_comb begin
    ra_sum     = {1'b0, read_add_q} + (AW+1)'(J);
    read_add_d = ra_sum[AW-1:0];
    if (ra_sum >= (AW+1)'(SIZE)) read_add_d = AW'(ra_sum - (AW+1)'(SIZE));
  end

  buf_occ_counter #(
    .SIZE (SIZE),
    .K    (K),
    .J    (J)
  ) u_occ (
    .clk        (clk),
    .rst        (rst),
    .ld_i       (ld),
    .fire_i     (fire),
    .count_o    (count),
    .wr_ok_o    (wr_ok),
    .overflow_o (overflow)
`ifdef BUFFER_READER_DROP_CNT_EN
    ,
    .drop_cnt_o (drop_cnt)
`endif
  );

  // NOTE: par_out is a plain output register, not storage, so it is reset with the rest.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      par_out_q   <= '0;
      read_add_q  <= '0;
    end else begin
      if (fire) begin
        state_q     <= HOLD;
        out_valid_q <= 1'b1;
        par_out_q   <= par_in;
        read_add_q  <= read_add_d;
      end else begin
        case (state_q)
          IDLE: begin
            out_valid_q <= 1'b0;
          end
          HOLD: begin
            if (out_ready) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
            end
          end
          default: begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_valid = out_valid_q;
  assign par_out   = par_out_q;
  assign read_add  = read_add_q;

endmodule

// File: tb/tb_buffer_reader.sv
// Bench for buffer_reader: cycle vector table, burst scoreboard, async reset
// mid-HOLD, and a SIZE=12 instance for non-power-of-two address wrap.
module tb_buffer_reader;
  import buffer_pkg::*;

  localparam int SIZE  = 16;
  localparam int WIDTH = 8;
  localparam int K     = 4;
  localparam int J     = 8;
  localparam int AW    = 4;
  localparam int CW    = 5;
  localparam int BW    = WIDTH * J;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld = 1'b0;
  logic          out_ready = 1'b0;
  logic          wr_ok, out_valid, overflow;
  logic [AW-1:0] read_add;
  logic [BW-1:0] par_in, par_out;

  logic          ld2 = 1'b0;
  logic          rdy2 = 1'b1;
  logic          wr_ok2, out_valid2, overflow2;
  logic [AW-1:0] read_add2;
  logic [BW-1:0] par_in2 = '0;
  logic [BW-1:0] par_out2;

`ifdef BUFFER_READER_DROP_CNT_EN
  logic [7:0] drop_cnt, drop_cnt2;
`endif

  always #5 clk = ~clk;

  buffer_reader #(.SIZE(SIZE), .WIDTH(WIDTH), .K(K), .J(J)) dut (
    .clk(clk), .rst(rst), .ld(ld), .wr_ok(wr_ok), .read_add(read_add),
    .par_in(par_in), .par_out(par_out), .out_valid(out_valid),
    .out_ready(out_ready), .overflow(overflow)
`ifdef BUFFER_READER_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  buffer_reader #(.SIZE(12), .WIDTH(WIDTH), .K(K), .J(J)) dut2 (
    .clk(clk), .rst(rst), .ld(ld2), .wr_ok(wr_ok2), .read_add(read_add2),
    .par_in(par_in2), .par_out(par_out2), .out_valid(out_valid2),
    .out_ready(rdy2), .overflow(overflow2)
`ifdef BUFFER_READER_DROP_CNT_EN
    , .drop_cnt(drop_cnt2)
`endif
  );

  // Buffer model: J words returned combinationally starting at read_add.
  logic [WIDTH-1:0] mem [SIZE];
  int               wptr = 0;

  always_comb begin
    par_in = '0;
    for (int i = 0; i < J; i++) par_in[i*WIDTH +: WIDTH] = mem[(int'(read_add) + i) % SIZE];
  end

  logic [WIDTH-1:0] words_q [$];
  logic [BW-1:0]    exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Writer side: fill K words, and form expected bursts in commit order.
  task automatic write_words();
    logic [BW-1:0] b;
    for (int k = 0; k < K; k++) begin
      logic [WIDTH-1:0] w;
      w = WIDTH'($urandom);
      mem[wptr] = w;
      words_q.push_back(w);
      wptr = (wptr + 1) % SIZE;
    end
    while (words_q.size() >= J) begin
      b = '0;
      for (int i = 0; i < J; i++) b[i*WIDTH +: WIDTH] = words_q.pop_front();
      exp_q.push_back(b);
    end
  endtask

  // Consumer side: a burst is taken at the edge following a valid&ready sample.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("burst_unexpected", par_out, '0);
        if (par_out == '0) begin
          n_err++;
          $display("FAIL burst_unexpected: got burst with no expected entry");
        end
      end else begin
        check("burst_data", par_out, exp_q.pop_front());
      end
    end
  end

  typedef struct {
    logic          ld;
    logic          rdy;
    logic          wr_ok;
    logic          valid;
    logic [AW-1:0] ra;
    logic [CW-1:0] cnt;
    logic          ovf;
  } vec_t;

  vec_t tv [25];
  logic model_ok;
  logic [AW-1:0] ra2_exp  [7];
  logic [CW-1:0] cnt2_exp [7];

  initial begin
    for (int i = 0; i < SIZE; i++) mem[i] = '0;

    //          ld    rdy   wr_ok valid ra     cnt     ovf
    tv[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 5'd4,  1'b0};
    tv[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 5'd8,  1'b0};
    tv[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd8, 5'd0,  1'b0};
    tv[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd8, 5'd4,  1'b0};
    tv[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd8, 5'd8,  1'b0};
    for (int i = 5; i <= 9; i++)
      tv[i] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd8, 5'd8, 1'b0};
    tv[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 5'd0,  1'b0};
    tv[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 5'd0,  1'b0};
    tv[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 5'd4,  1'b0};
    tv[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 5'd8,  1'b0};
    tv[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd8, 5'd4,  1'b0};
    tv[15] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd8, 5'd8,  1'b0};
    tv[16] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd8, 5'd12, 1'b0};
    tv[17] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 5'd8,  1'b0};
    tv[18] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 5'd8,  1'b0};
    tv[19] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 5'd12, 1'b0};
    tv[20] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 5'd16, 1'b0};
    tv[21] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 5'd16, 1'b1};
    tv[22] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd8, 5'd8,  1'b1};
    tv[23] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 5'd0,  1'b1};
    tv[24] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 5'd0,  1'b1};

    ra2_exp  = '{4'd0, 4'd0, 4'd8, 4'd8, 4'd4, 4'd4, 4'd0};
    cnt2_exp = '{5'd4, 5'd8, 5'd4, 5'd8, 5'd4, 5'd8, 5'd0};

    // Reset values while rst is held low, before any clock edge.
    #2 rst = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_read_add", read_add, 0);
    check("rst_par_out", par_out, 0);
    check("rst_overflow", overflow, 0);
    check("rst_wr_ok", wr_ok, 1);
    check("rst_count", dut.count, 0);
`ifdef BUFFER_READER_DROP_CNT_EN
    check("rst_drop_cnt", drop_cnt, 0);
`endif
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;

    model_ok = 1'b1;
    for (int i = 0; i < 25; i++) begin
      ld        = tv[i].ld;
      out_ready = tv[i].rdy;
      if (tv[i].ld && model_ok) write_words();
      @(posedge clk) #1;
      check($sformatf("v%0d_wr_ok", i), wr_ok, tv[i].wr_ok);
      check($sformatf("v%0d_valid", i), out_valid, tv[i].valid);
      check($sformatf("v%0d_read_add", i), read_add, tv[i].ra);
      check($sformatf("v%0d_count", i), dut.count, tv[i].cnt);
      check($sformatf("v%0d_overflow", i), overflow, tv[i].ovf);
      model_ok = tv[i].wr_ok;
    end
    ld = 1'b0;
    out_ready = 1'b0;
`ifdef BUFFER_READER_DROP_CNT_EN
    check("drop_cnt_one", drop_cnt, 1);
`endif

    // Async reset in the middle of a held burst.
    ld = 1'b1; write_words();
    @(posedge clk) #1;
    write_words();
    @(posedge clk) #1;
    ld = 1'b0;
    @(posedge clk) #1;
    check("hold_valid", out_valid, 1);
    check("hold_read_add", read_add, 8);
    #2 rst = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_read_add", read_add, 0);
    check("midrst_count", dut.count, 0);
    check("midrst_par_out", par_out, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_wr_ok", wr_ok, 1);
`ifdef BUFFER_READER_DROP_CNT_EN
    check("midrst_drop_cnt", drop_cnt, 0);
`endif
    words_q.delete();
    exp_q.delete();
    wptr = 0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;

    // Recovery after reset: fresh burst from address 0, then handshake.
    ld = 1'b1; write_words();
    @(posedge clk) #1;
    write_words();
    @(posedge clk) #1;
    ld = 1'b0;
    out_ready = 1'b1;
    @(posedge clk) #1;
    check("rec_valid", out_valid, 1);
    check("rec_read_add", read_add, 8);
    check("rec_count", dut.count, 0);
    @(posedge clk) #1;
    check("rec_idle", out_valid, 0);
    out_ready = 1'b0;

    // SIZE=12 instance: read_add walks 0, 8, 4, 0.
    for (int e = 0; e < 7; e++) begin
      ld2 = (e < 6);
      @(posedge clk) #1;
      check($sformatf("s12_e%0d_read_add", e), read_add2, ra2_exp[e]);
      check($sformatf("s12_e%0d_count", e), dut2.count, cnt2_exp[e]);
    end
    ld2 = 1'b0;
    check("s12_overflow", overflow2, 0);

    @(posedge clk) #1;
    check("sb_drain", BW'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/buffer_reader.md
BUFFER_READER -- requirements
Module: buffer_reader

Interface
REQ-001 SHALL have parameter SIZE, default 16, meaning circular buffer depth in words.
REQ-002 SHALL have parameter WIDTH, default 8, meaning word width in bits.
REQ-003 SHALL have parameter K, default 4, meaning words committed per writer ld pulse.
REQ-004 SHALL have parameter J, default 8, meaning words removed per read burst; J <= SIZE and K <= SIZE.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port ld, input, 1 bit, writer commit pulse: K new words present in the buffer.
REQ-008 SHALL have port wr_ok, output, 1 bit, high when at least K free words remain.
REQ-009 SHALL have port read_add, output, $clog2(SIZE) bits, buffer read address of the oldest unread word.
REQ-010 SHALL have port par_in, input, WIDTH*J bits, J words returned combinationally by the buffer at read_add.
REQ-011 SHALL have port par_out, output, WIDTH*J bits, registered burst to the consumer.
REQ-012 SHALL have port out_valid, output, 1 bit, par_out holds an unconsumed burst.
REQ-013 SHALL have port out_ready, input, 1 bit, consumer accepts par_out this cycle.
REQ-014 SHALL have port overflow, output, 1 bit, sticky flag: an ld arrived without space.

Function
REQ-015 SHALL track occupancy count, width $clog2(SIZE)+1, range 0..SIZE.
REQ-016 SHALL accept ld only when wr_ok is high (count <= SIZE-K); accepted ld adds K.
REQ-017 SHALL drop ld when wr_ok is low, leave count unchanged and set overflow until reset.
REQ-018 SHALL implement FSM states IDLE (out_valid low), HOLD (out_valid high, waiting on out_ready).
REQ-019 SHALL fire a burst when count >= J and (state IDLE or (HOLD and out_ready)).
REQ-020 SHALL, on a fire, register par_in into par_out, set out_valid next cycle, subtract J from count, advance read_add by J modulo SIZE.
REQ-021 SHALL have read latency of one cycle: fire at edge N, burst visible on par_out after edge N.
REQ-022 SHALL go HOLD->IDLE when out_ready is high and no fire occurs; out_valid drops next cycle.
REQ-023 SHALL keep par_out and out_valid stable in HOLD while out_ready is low.
REQ-024 SHALL, on simultaneous accepted ld and fire, update count by K-J in one cycle; wr_ok uses pre-update count.
REQ-025 SHALL wrap read_add modulo SIZE, including non-power-of-two remainder when J does not divide SIZE.
REQ-026 SHALL ignore out_ready in IDLE.

Reset
REQ-027 SHALL on rst low immediately force count 0, read_add 0, state IDLE, out_valid 0, par_out 0, overflow 0, wr_ok 1.
REQ-028 SHALL discard any in-flight or held burst on reset mid-operation; no partial state survives.

Configuration
REQ-029 SHALL compile an 8-bit saturating dropped-ld counter output drop_cnt only when macro BUFFER_READER_DROP_CNT_EN is defined; increments per dropped ld, saturates at 255, reset to 0.
REQ-030 SHALL, without BUFFER_READER_DROP_CNT_EN, omit drop_cnt port and logic; all other behaviour identical.

Structure
REQ-031 SHALL place address-width and count-width constants plus FSM state encoding in shared package buffer_pkg.
REQ-032 SHALL implement occupancy tracking (count, wr_ok, overflow) in sub-module buf_occ_counter.

Verification
REQ-033 SHALL test: after reset, two ld pulses (K=4) -> count 8, one cycle later out_valid=1, par_out = par_in sampled at read_add 0, read_add 8.
REQ-034 SHALL test: out_ready held low 5 cycles with count 8 -> par_out, read_add unchanged; out_ready high -> next burst fires same edge, read_add 0 (wrap at 16).
REQ-035 SHALL test: five ld pulses with no reads -> fifth ld dropped, count 16, wr_ok 0, overflow 1, drop_cnt 1 when macro defined.
REQ-036 SHALL test: ld and fire same edge with count 12 -> count 8.
REQ-037 SHALL test: rst low asynchronously mid-HOLD -> out_valid 0, read_add 0, count 0 before next clk edge.
REQ-038 SHALL test: SIZE=12, J=8 build -> read_add sequence 0, 8, 4, 0.
